// File: rtl/axi_bram_reader_pkg.sv
// Shared definitions for the BRAM reader/writer pair: address mapping helper,
// FSM state type and the fixed AXI response code.
package axi_bram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Number of bits needed to represent value; clogb2(3) = 2 for a 4-byte bus.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_bram_reader_if.sv
// AXI4-Lite read channels (AR + R) between interconnect master and reader slave.
interface axi_bram_reader_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_bram_reader.sv
// Single-outstanding AXI4-Lite read slave: one AXI read becomes one BRAM
// port-A read, and the captured word is returned on the R channel.
module axi_bram_reader
  import axi_bram_reader_pkg::*;
#(
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int BRAM_DATA_WIDTH   = 32,
  parameter int BRAM_ADDR_WIDTH   = 10,
  parameter int BRAM_READ_LATENCY = 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  axi_bram_reader_if.slave           s_axi,
  output logic                       bram_porta_clk,
  output logic                       bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_porta_rddata,
  output logic                       bram_porta_en
);

  localparam int         ADDR_LSB = clogb2(AXI_DATA_WIDTH/8 - 1);
  localparam logic [1:0] LAT_M1   = 2'(BRAM_READ_LATENCY - 1);

  state_t                      r_state, w_next;
  logic [1:0]                  r_cnt;
  logic [BRAM_ADDR_WIDTH-1:0]  r_addr;
  logic [AXI_DATA_WIDTH-1:0]   r_rdata;
  logic                        w_unused_araddr;

  // Byte-offset and upper address bits are dropped, so addresses alias.
  assign w_unused_araddr = ^s_axi.araddr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (s_axi.arvalid) w_next = ST_READ;
      ST_READ: w_next = ST_WAIT;
      ST_WAIT: if (r_cnt == 2'd0) w_next = ST_RESP;
      ST_RESP: if (s_axi.rready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == ST_IDLE && s_axi.arvalid)
        r_addr <= s_axi.araddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
      if (r_state == ST_READ)
        r_cnt <= LAT_M1;
      if (r_state == ST_WAIT) begin
        if (r_cnt == 2'd0) r_rdata <= AXI_DATA_WIDTH'(bram_porta_rddata);
        else               r_cnt   <= r_cnt - 2'd1;
      end
    end
  end

  // Handshake outputs decode straight from state so reset clears rvalid at once.
  assign s_axi.arready   = (r_state == ST_IDLE);
  assign s_axi.rvalid    = (r_state == ST_RESP);
  assign s_axi.rdata     = r_rdata;
  assign s_axi.rresp     = RESP_OKAY;

  assign bram_porta_clk  = aclk;
  assign bram_porta_rst  = ~aresetn;
  assign bram_porta_addr = r_addr;
  assign bram_porta_en   = (r_state == ST_READ);

endmodule

// File: tb/tb_axi_bram_reader.sv
// Directed bench: latency-1 and latency-2 readers driven by the same AR/R
// stimulus, each with its own BRAM model over a shared memory image.
module tb_axi_bram_reader;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] araddr;
  logic        arvalid, rready;

  always #5 aclk = ~aclk;

  axi_bram_reader_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) ax1 ();
  axi_bram_reader_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) ax2 ();

  assign ax1.araddr = araddr;  assign ax1.arvalid = arvalid;  assign ax1.rready = rready;
  assign ax2.araddr = araddr;  assign ax2.arvalid = arvalid;  assign ax2.rready = rready;

  logic        clk1, rst1, en1, clk2, rst2, en2;
  logic [9:0]  addr1, addr2;
  logic [31:0] rd1, rd2, q1a, q2a, q2b;
  logic [31:0] mem [0:1023];

  axi_bram_reader #(.BRAM_READ_LATENCY(1)) u_l1 (
    .aclk(aclk), .aresetn(aresetn), .s_axi(ax1),
    .bram_porta_clk(clk1), .bram_porta_rst(rst1), .bram_porta_addr(addr1),
    .bram_porta_rddata(rd1), .bram_porta_en(en1)
  );

  axi_bram_reader #(.BRAM_READ_LATENCY(2)) u_l2 (
    .aclk(aclk), .aresetn(aresetn), .s_axi(ax2),
    .bram_porta_clk(clk2), .bram_porta_rst(rst2), .bram_porta_addr(addr2),
    .bram_porta_rddata(rd2), .bram_porta_en(en2)
  );

  // Latency 1: plain synchronous read. Latency 2: extra output register.
  always @(posedge aclk) if (en1) q1a <= mem[addr1];
  always @(posedge aclk) begin
    if (en2) q2a <= mem[addr2];
    q2b <= q2a;
  end
  assign rd1 = q1a;
  assign rd2 = q2b;

  int checks = 0;
  int errors = 0;
  int en_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0; arvalid = 1'b0; rready = 1'b0; araddr = '0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  // Starts at a negedge with both readers idle; cycle 0 is the handshake cycle.
  task automatic single_read(input logic [31:0] a, input logic [31:0] exp, input logic [9:0] ea);
    chk("arready_idle", ax1.arready, 1);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    @(negedge aclk); arvalid = 1'b0;
    chk("en_c1", en1, 1);
    chk("addr_c1", addr1, ea);
    chk("arready_c1", ax1.arready, 0);
    chk("rvalid_c1", ax1.rvalid, 0);
    @(negedge aclk);
    chk("en_c2", en1, 0);
    chk("rvalid_c2", ax1.rvalid, 0);
    @(negedge aclk);
    chk("rvalid_c3", ax1.rvalid, 1);
    chk("rdata_c3", ax1.rdata, exp);
    chk("rresp_c3", ax1.rresp, 0);
    chk("l2_rvalid_c3", ax2.rvalid, 0);
    @(negedge aclk);
    chk("rvalid_c4", ax1.rvalid, 0);
    chk("arready_c4", ax1.arready, 1);
    chk("l2_rvalid_c4", ax2.rvalid, 1);
    chk("l2_rdata_c4", ax2.rdata, exp);
    @(negedge aclk);
    chk("l2_rvalid_c5", ax2.rvalid, 0);
    chk("l2_arready_c5", ax2.arready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'h0000_1111;
    mem[1] = 32'h2222_0001;
    mem[2] = 32'h3333_0002;
    mem[5] = 32'hDEAD_BEEF;
    mem[7] = 32'h1234_5678;

    aresetn = 1'b0; arvalid = 1'b0; rready = 1'b0; araddr = '0;
    @(negedge aclk);
    chk("rst_arready", ax1.arready, 1);
    chk("rst_rvalid", ax1.rvalid, 0);
    chk("rst_en", en1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_rdata", ax1.rdata, 0);
    chk("rst_bram_rst", rst1, 1);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("bram_rst_rel", rst1, 0);

    single_read(32'h14, 32'hDEAD_BEEF, 10'd5);

    // Backpressure: rvalid held for 11 cycles before rready
    araddr = 32'h14; arvalid = 1'b1; rready = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge aclk);
      if (k == 1) arvalid = 1'b0;
      chk("bp_arready", ax1.arready, (k == 14));
      chk("bp_rvalid", ax1.rvalid, (k >= 3 && k <= 13));
      if (k >= 3 && k <= 13) chk("bp_rdata", ax1.rdata, 32'hDEAD_BEEF);
      if (k == 13) rready = 1'b1;
    end
    chk("bp_l2_rvalid", ax2.rvalid, 0);

    single_read(32'h1016, 32'hDEAD_BEEF, 10'd5);

    // Back-to-back with arvalid held: handshakes at cycles 0, 4, 8
    araddr = 32'h0; arvalid = 1'b1; rready = 1'b1; en_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge aclk);
      if (en1) en_cnt++;
      chk("b2b_en", en1, (k % 4 == 1));
      if (k % 4 == 1) chk("b2b_addr", addr1, k / 4);
      chk("b2b_arready", ax1.arready, (k % 4 == 0));
      chk("b2b_rvalid", ax1.rvalid, (k % 4 == 3));
      if (k % 4 == 3) chk("b2b_rdata", ax1.rdata, mem[k / 4]);
      if (k == 1) araddr = 32'h4;
      if (k == 5) araddr = 32'h8;
      if (k == 9) arvalid = 1'b0;
    end
    chk("b2b_en_cnt", en_cnt, 3);
    do_reset();

    // Reset during WAIT, then a clean read
    araddr = 32'h14; arvalid = 1'b1; rready = 1'b1;
    @(negedge aclk); arvalid = 1'b0;
    @(negedge aclk);
    chk("mid_en_wait", en1, 0);
    aresetn = 1'b0;
    #1;
    chk("mid_rvalid_async", ax1.rvalid, 0);
    chk("mid_arready_async", ax1.arready, 1);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      chk("post_rst_rvalid", ax1.rvalid, 0);
      chk("post_rst_l2_rvalid", ax2.rvalid, 0);
    end
    single_read(32'h1C, 32'h1234_5678, 10'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
